ct_ifu_icache_tag_ctrl: RTL
===========================

Name: ct_ifu_icache_tag_ctrl

Overview:
Controller that drives and consumes the 256x59 instruction-cache tag SRAM in the IFU.
- Entry layout: bit 58 = LRU; bits 57:29 = way1 {valid, tag}; bits 28:0 = way0 {valid, tag}.
- Operations: 2-way tag lookup with hit/way/victim results, refill writes, LRU hint updates, and a full-array invalidate sweep after reset or on request.
- Owns the single SRAM port and arbitrates between these operations.

Parameters:
- IDX_WIDTH, 8, SRAM address width (256 sets).
- TAG_WIDTH, 28, tag bits per way.
- DATA_WIDTH, 59, SRAM word width; must equal 2*(TAG_WIDTH+1)+1.

Ports:
- forever_cpuclk  in  1  clock; SRAM CLK is tied to the same clock.
- cpurst  in  1  synchronous active-high reset.
- lkup_vld  in  1  lookup request.
- lkup_idx  in  IDX_WIDTH  lookup set.
- lkup_tag  in  TAG_WIDTH  lookup tag.
- lkup_rdy  out  1  lookup accepted when lkup_vld & lkup_rdy.
- rslt_vld  out  1  result valid.
- rslt_hit  out  1  tag hit.
- rslt_way  out  1  hit way; when rslt_hit=0, the victim way (LRU bit).
- refill_vld  in  1  refill write request.
- refill_idx  in  IDX_WIDTH  refill set.
- refill_tag  in  TAG_WIDTH  refill tag.
- refill_way  in  1  way to write.
- refill_rdy  out  1  refill accepted when refill_vld & refill_rdy.
- inv_req  in  1  invalidate-all pulse.
- inv_busy  out  1  sweep in progress.
- inv_done  out  1  one-cycle pulse at the final sweep write.
- sram_a  out  IDX_WIDTH  SRAM address.
- sram_cen  out  1  SRAM chip enable, active low.
- sram_gwen  out  1  SRAM global write enable, active low.
- sram_wen  out  DATA_WIDTH  SRAM per-bit write enable, active low (0 = write bit).
- sram_d  out  DATA_WIDTH  SRAM write data.
- sram_q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read.

Behaviour:
- Clock and reset: one clock, forever_cpuclk. cpurst is synchronous and active-high.
- Reset values: state=SWEEP, cnt=0, inv_busy=1, rslt_vld=0, inv_done=0, lkup_rdy=0, refill_rdy=0, no LRU write pending.
- SRAM idle encoding: sram_cen=1, sram_gwen=1, sram_wen all ones, sram_a=0, sram_d=0. This holds whenever no access is issued, including every cycle cpurst is high.
- SRAM controls are decoded combinationally from registered state and the accepted request.
- FSM states:
  - SWEEP: each cycle writes D=0, WEN=0 (all bits) at A=cnt, then cnt++. At cnt=255, inv_done=1 and the next state is IDLE.
  - IDLE: arbitrates the port.
  - inv_req in IDLE → SWEEP with cnt=0 and pending LRU write cleared.
  - inv_req in SWEEP restarts cnt at 0.
- Port priority in IDLE (one access per cycle): refill > pending LRU write > lookup. refill_rdy = (state==IDLE). lkup_rdy = IDLE & !refill_vld & !lru_pend.
- Lookup:
  - Accepted in cycle N: read at lkup_idx; index and tag are registered.
  - Cycle N+1: rslt_vld=1.
  - hit = valid & tag match per way. rslt_way = hit way, or Q[58] on a miss.
  - Both ways hitting is an error; way0 is reported.
- LRU update: on a hit in N+1, if Q[58] equals the hit way, set lru_pend with the new LRU value (~hit way) and the index.
  - The write issues in the first later IDLE cycle: WEN=0 only on bit 58, GWEN=0.
  - The LRU bit is a hint. A lookup in N+1 to the same set reading the stale LRU is permitted.
- Refill write: GWEN=0; WEN=0 on the selected way's 29 bits and on bit 58. D = {~refill_way, tag fields}, with the selected way's valid=1.
  - A pending LRU write to the same index is dropped. A pending write to a different index stays pending.
- A lookup accepted in the final IDLE cycle before inv_req still returns its result in the next cycle. Its LRU update is discarded.
- Reset mid-sweep restarts the sweep at cnt=0.

Decomposition:
- Shared package ct_ifu_icache_pkg:
  - IDX_WIDTH, TAG_WIDTH, WAY_BITS=TAG_WIDTH+1.
  - Bit-position constants: LRU_BIT=58, WAY1_LSB=29, WAY0_LSB=0, and the valid-bit offset.
  - Typedef tag_way_t {valid, tag}.
  - Typedef fsm_e {SWEEP, IDLE}.
- One sub-module: ct_ifu_icache_tag_cmp, combinational 2-way compare producing hit, way, and the LRU-write-needed flag.

Test Plan:
- Reset 1 cycle, then release → 256 consecutive writes at A=0..255 with D=0 and WEN=0. inv_done pulses at A=255. lkup_rdy=0 throughout, then 1.
- Refill idx=0x12, tag=0xABCDEF1, way=1 → A=0x12, WEN[57:29]=0, WEN[58]=0, D[57]=1, D[56:29]=0xABCDEF1, D[58]=0.
- Lookup idx=0x12, tag=0xABCDEF1, SRAM returns that entry with LRU=1 → next cycle rslt_hit=1, rslt_way=1, followed by an LRU write (WEN only bit 58=0, D[58]=0).
- Lookup miss, both ways invalid, Q[58]=1 → rslt_hit=0, rslt_way=1, no SRAM write issued.
- Pending LRU write to idx 5 and refill to idx 5 in the same cycle → refill write issues, LRU write dropped, lkup_rdy=1 on the next cycle.
- inv_req at sweep cnt=100 → cnt restarts at 0. Exactly 256 further writes occur, then IDLE.

Source files
------------

// File: rtl/ct_ifu_icache_pkg.sv
// Shared layout constants and types for the IFU instruction-cache tag array.
package ct_ifu_icache_pkg;

  localparam int unsigned IDX_WIDTH  = 8;
  localparam int unsigned TAG_WIDTH  = 28;
  localparam int unsigned WAY_BITS   = TAG_WIDTH + 1;
  localparam int unsigned DATA_WIDTH = 2 * WAY_BITS + 1;

  // Entry: {lru, way1 {valid, tag}, way0 {valid, tag}}
  localparam int unsigned LRU_BIT  = 2 * WAY_BITS;
  localparam int unsigned WAY1_LSB = WAY_BITS;
  localparam int unsigned WAY0_LSB = 0;
  localparam int unsigned VLD_OFS  = TAG_WIDTH;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
  } tag_way_t;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } fsm_e;

endpackage

// File: rtl/ct_ifu_icache_tag_cmp.sv
// Two-way tag compare on a raw SRAM entry: hit, reported way, and whether the
// LRU bit has to be flipped away from the way just used.
module ct_ifu_icache_tag_cmp
  import ct_ifu_icache_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] q,
  input  logic [TAG_WIDTH-1:0]  tag,
  output logic                  hit,
  output logic                  way,
  output logic                  lru_upd
);

  logic hit0;
  logic hit1;

  always_comb begin
    hit0 = q[WAY0_LSB + VLD_OFS] && (q[WAY0_LSB +: TAG_WIDTH] == tag);
    hit1 = q[WAY1_LSB + VLD_OFS] && (q[WAY1_LSB +: TAG_WIDTH] == tag);
    hit  = hit0 || hit1;
    // A double hit is an error upstream; way0 wins so the result stays deterministic.
    way     = hit0 ? 1'b0 : (hit1 ? 1'b1 : q[LRU_BIT]);
    lru_upd = hit && (q[LRU_BIT] == way);
  end

endmodule

// File: rtl/ct_ifu_icache_tag_ctrl.sv
// Tag SRAM controller: invalidate sweep, refill writes, LRU hint writes and
// 2-way lookups sharing the single SRAM port.
module ct_ifu_icache_tag_ctrl #(
  parameter int unsigned IDX_WIDTH  = ct_ifu_icache_pkg::IDX_WIDTH,
  parameter int unsigned TAG_WIDTH  = ct_ifu_icache_pkg::TAG_WIDTH,
  parameter int unsigned DATA_WIDTH = ct_ifu_icache_pkg::DATA_WIDTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  lkup_vld,
  input  logic [IDX_WIDTH-1:0]  lkup_idx,
  input  logic [TAG_WIDTH-1:0]  lkup_tag,
  output logic                  lkup_rdy,
  output logic                  rslt_vld,
  output logic                  rslt_hit,
  output logic                  rslt_way,
  input  logic                  refill_vld,
  input  logic [IDX_WIDTH-1:0]  refill_idx,
  input  logic [TAG_WIDTH-1:0]  refill_tag,
  input  logic                  refill_way,
  output logic                  refill_rdy,
  input  logic                  inv_req,
  output logic                  inv_busy,
  output logic                  inv_done,
  output logic [IDX_WIDTH-1:0]  sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  import ct_ifu_icache_pkg::*;

  fsm_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [IDX_WIDTH-1:0] lk_idx_q, lk_idx_d;
  logic [TAG_WIDTH-1:0] lk_tag_q, lk_tag_d;
  logic                 lru_pend_q, lru_pend_d;
  logic [IDX_WIDTH-1:0] lru_idx_q, lru_idx_d;
  logic                 lru_val_q, lru_val_d;

  logic     cmp_hit;
  logic     cmp_way;
  logic     cmp_lru_upd;
  tag_way_t new_way;

  ct_ifu_icache_tag_cmp u_cmp (
    .q       (sram_q),
    .tag     (lk_tag_q),
    .hit     (cmp_hit),
    .way     (cmp_way),
    .lru_upd (cmp_lru_upd)
  );

  assign rslt_vld = rd_pend_q;
  assign rslt_hit = rd_pend_q & cmp_hit;
  assign rslt_way = rd_pend_q & cmp_way;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_pend_d  = 1'b0;
    lk_idx_d   = lk_idx_q;
    lk_tag_d   = lk_tag_q;
    lru_pend_d = lru_pend_q;
    lru_idx_d  = lru_idx_q;
    lru_val_d  = lru_val_q;
    lkup_rdy   = 1'b0;
    refill_rdy = 1'b0;
    inv_done   = 1'b0;
    inv_busy   = (state_q == SWEEP);
    sram_cen   = 1'b1;
    sram_gwen  = 1'b1;
    sram_wen   = '1;
    sram_a     = '0;
    sram_d     = '0;
    new_way.valid = 1'b1;
    new_way.tag   = refill_tag;

    if (cpurst) begin
      state_d = SWEEP;
    end else if (state_q == SWEEP) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = cnt_q;
      cnt_d     = cnt_q + 1'b1;
      if (inv_req) begin
        cnt_d = '0;
      end else if (cnt_q == '1) begin
        inv_done = 1'b1;
        state_d  = IDLE;
      end
    end else begin
      refill_rdy = 1'b1;
      lkup_rdy   = !refill_vld && !lru_pend_q;
      if (refill_vld) begin
        sram_cen          = 1'b0;
        sram_gwen         = 1'b0;
        sram_a            = refill_idx;
        sram_wen[LRU_BIT] = 1'b0;
        sram_d[LRU_BIT]   = ~refill_way;
        if (refill_way) begin
          sram_wen[WAY1_LSB +: WAY_BITS] = '0;
          sram_d[WAY1_LSB +: WAY_BITS]   = new_way;
        end else begin
          sram_wen[WAY0_LSB +: WAY_BITS] = '0;
          sram_d[WAY0_LSB +: WAY_BITS]   = new_way;
        end
        if (lru_pend_q && (lru_idx_q == refill_idx)) lru_pend_d = 1'b0;
      end else if (lru_pend_q) begin
        sram_cen          = 1'b0;
        sram_gwen         = 1'b0;
        sram_a            = lru_idx_q;
        sram_wen[LRU_BIT] = 1'b0;
        sram_d[LRU_BIT]   = lru_val_q;
        lru_pend_d        = 1'b0;
      end else if (lkup_vld) begin
        sram_cen  = 1'b0;
        sram_a    = lkup_idx;
        rd_pend_d = 1'b0 | 1'b1;
        lk_idx_d  = lkup_idx;
        lk_tag_d  = lkup_tag;
      end
      // A fresh hint supersedes one still waiting behind a refill; the bit is only a hint.
      if (rd_pend_q && cmp_lru_upd) begin
        lru_pend_d = 1'b1;
        lru_idx_d  = lk_idx_q;
        lru_val_d  = ~cmp_way;
      end
      if (inv_req) begin
        state_d    = SWEEP;
        cnt_d      = '0;
        lru_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q    <= SWEEP;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      lru_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      lru_pend_q <= lru_pend_d;
    end
    lk_idx_q  <= lk_idx_d;
    lk_tag_q  <= lk_tag_d;
    lru_idx_q <= lru_idx_d;
    lru_val_q <= lru_val_d;
  end

endmodule
